// File: rtl/hs_pkg.sv
// Shared types and defaults for the request-path transmit driver.
package hs_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReqHi = 2'd1,
    StReqLo = 2'd2,
    StGap   = 2'd3
  } hs_state_t;

  localparam int unsigned HS_MIN_PULSE = 4;
  localparam int unsigned HS_TIMEOUT   = 255;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_req_driver.sv
// Turns a one-cycle send strobe into a registered, width-guaranteed request level, either as
// a 4-phase req/ack exchange or as a fixed-width pulse.
module handshake_req_driver
  import hs_pkg::*;
#(
  parameter int unsigned MIN_PULSE   = HS_MIN_PULSE,
  parameter int unsigned TIMEOUT     = HS_TIMEOUT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic send_i,
  input  logic mode_i,
  input  logic ack_i,
  output logic req_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o,
  output logic drop_o
);

  localparam int unsigned PW = $clog2(MIN_PULSE + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] PulseSat  = PW'(MIN_PULSE);
  localparam logic [PW-1:0] PulseLast = PW'(MIN_PULSE - 1);
  localparam logic [PW-1:0] PulsePre  = PW'(MIN_PULSE - 2);
  localparam logic [WW-1:0] WaitSat   = WW'(TIMEOUT);
  localparam logic [WW-1:0] WaitPre   = WW'(TIMEOUT - 2);

  hs_state_t         state_q, state_d;
  logic              mode_q, mode_d;
  logic [PW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              drop_q, drop_d;
  logic              ack_s;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // done/timeout pulses are decided one cycle early so they land in the last busy cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (send_i) state_d = StReqHi;
      end
      StReqHi: begin
        if (timeout_q) begin
          state_d = StGap;
        end else if (pulse_cnt_q >= PulseLast && (mode_q || ack_s)) begin
          state_d = StReqLo;
        end
      end
      StReqLo: begin
        if (done_q || timeout_q) state_d = StIdle;
      end
      StGap: begin
        if (pulse_cnt_q >= PulseLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    if (state_q == StIdle && send_i) mode_d = mode_i;

    if (state_d != state_q) begin
      pulse_cnt_d = '0;
      wait_cnt_d  = '0;
    end else begin
      if (state_q != StIdle && pulse_cnt_q != PulseSat) begin
        pulse_cnt_d = pulse_cnt_q + PW'(1);
      end
      if (!mode_q && wait_cnt_q != WaitSat &&
          ((state_q == StReqHi && !ack_s) || (state_q == StReqLo && ack_s))) begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end
    end

    if (state_d == state_q) begin
      if (state_q == StReqHi) begin
        timeout_d = !mode_q && !ack_s && (wait_cnt_q == WaitPre);
      end else if (state_q == StReqLo) begin
        if (pulse_cnt_q >= PulsePre && (mode_q || !ack_s)) begin
          done_d = 1'b1;
        end else if (!mode_q && ack_s && wait_cnt_q == WaitPre) begin
          timeout_d = 1'b1;
        end
      end
    end

    req_d  = (state_d == StReqHi);
    busy_d = (state_d != StIdle);
    drop_d = send_i && (state_q != StIdle);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q      <= 1'b0;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      drop_q      <= drop_d;
    end
  end

  assign req_o     = req_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign drop_o    = drop_q;

endmodule
